dmem_ctrl: RTL
==============

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles waiting on bus_gnt or bus_rvalid before error.
REQ-002 clk  in  1  single clock, all state on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset (reset=0 resets).
REQ-004 MemReadM  in  1  memory-stage load request.
REQ-005 MemWriteM  in  1  memory-stage store request.
REQ-006 Funct3M  in  3  access size/sign: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; stores use 000/001/010.
REQ-007 ALUResultM  in  32  byte address.
REQ-008 WriteDataM  in  32  store data, right-aligned.
REQ-009 ReadDataM  out  32  extended load result, valid when StallM=0 after a load.
REQ-010 StallM  out  1  hold pipeline while access in flight.
REQ-011 MisalignM  out  1  combinational misaligned-access flag.
REQ-012 BusErrM  out  1  one-cycle pulse on timeout.
REQ-013 bus_req, bus_we  out  1 each  bus request / write enable.
REQ-014 bus_addr  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 bus_wdata  out  32; bus_be  out  4  lane-replicated store data, byte enables.
REQ-016 bus_gnt, bus_rvalid  in  1 each; bus_rdata  in  32.

Function
REQ-017 States IDLE, REQ, WAIT, DONE; encoding free.
REQ-018 Access = (MemReadM|MemWriteM) & !MisalignM; MemWriteM takes priority when both asserted.
REQ-019 MisalignM = access requested & ((half & addr[0]) | (word & addr[1:0]!=0)); misaligned access issues no bus cycle and no stall.
REQ-020 IDLE: on Access, StallM=1 combinationally same cycle; latch addr, be, wdata, we, Funct3M; next REQ.
REQ-021 REQ: bus_req=1 with latched fields, StallM=1; on bus_gnt, write -> DONE, read -> WAIT; read with bus_gnt and bus_rvalid same cycle captures data -> DONE.
REQ-022 WAIT: bus_req=0, StallM=1; on bus_rvalid capture extended bus_rdata -> DONE.
REQ-023 DONE: StallM=0, ReadDataM=captured value; unconditionally -> IDLE (no restart on still-asserted inputs).
REQ-024 Minimum latency: write 2 stall cycles (IDLE, REQ) with immediate gnt; read 2 with gnt+rvalid together, 3 with rvalid one cycle after gnt.
REQ-025 Byte store: bus_be = 4'b0001<<addr[1:0], wdata = {4{WriteDataM[7:0]}}; half: be = 4'b0011<<addr[1:0], wdata = {2{WriteDataM[15:0]}}; word: be=4'b1111.
REQ-026 Load: select byte/half at addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through.
REQ-027 Timeout counter cleared on entering REQ or WAIT, increments each cycle there; reaching TIMEOUT -> BusErrM pulse, ReadDataM=0, next DONE.
REQ-028 ReadDataM holds last captured value in IDLE.
REQ-029 No new request accepted until IDLE; bus_req never asserted in IDLE, WAIT or DONE.

Reset
REQ-030 reset=0 asynchronously forces IDLE, StallM=0, bus_req=0, bus_we=0, BusErrM=0, ReadDataM=0, timeout counter=0, latched fields 0.
REQ-031 Reset mid-transaction drops bus_req immediately; a late bus_rvalid after reset release is ignored in IDLE.

Verification
REQ-032 sw 0xDEADBEEF @0x100, gnt immediate -> bus_addr=0x100, be=1111, we=1, StallM high 2 cycles, then IDLE.
REQ-033 lb @0x203, rdata=0x80FF_FF_FF with rvalid 3 cycles after gnt -> ReadDataM=0xFFFFFF80; lbu same -> 0x00000080.
REQ-034 sh 0x1234 @0x12 -> be=1100, wdata=0x12341234; lh @0x11 -> MisalignM=1, bus_req never asserted, StallM=0.
REQ-035 lw with bus_gnt held low, TIMEOUT=8 -> BusErrM pulse after 8 REQ cycles, ReadDataM=0, StallM releases next cycle.
REQ-036 reset=0 asserted in WAIT -> state IDLE, StallM=0 same cycle; rvalid after release ignored, ReadDataM stays 0.
REQ-037 MemReadM and MemWriteM both 1 -> single write cycle (we=1), no read.

Source files
------------

// File: rtl/dmem_ctrl.sv
// rtl/dmem_ctrl.sv - data-memory controller: sized, aligned loads/stores over a req/gnt/rvalid bus
// One access in flight; stalls the pipeline until the bus completes or times out.
module dmem_ctrl #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [2:0]  Funct3M,
   input  logic [31:0] ALUResultM,
   input  logic [31:0] WriteDataM,
   output logic [31:0] ReadDataM,
   output logic        StallM,
   output logic        MisalignM,
   output logic        BusErrM,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_be,
   input  logic        bus_gnt,
   input  logic        bus_rvalid,
   input  logic [31:0] bus_rdata
);

   localparam int            CW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t        state_q;
   logic [CW-1:0] cnt_q;
   logic [31:0]   addr_q;
   logic [3:0]    be_q;
   logic [31:0]   wdata_q;
   logic          we_q;
   logic [2:0]    f3_q;
   logic [31:0]   rdata_q;
   logic          bus_req_q;
   logic          buserr_q;

   logic          req_any;
   logic          access;
   logic [3:0]    be_d;
   logic [31:0]   wdata_d;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   ld_data_d;

   // Funct3M[1] covers lw and the unused 011 encoding alike.
   assign req_any   = MemReadM | MemWriteM;
   assign MisalignM = req_any & (((Funct3M[1:0] == 2'b01) & ALUResultM[0]) |
                                 (Funct3M[1] & (ALUResultM[1:0] != 2'b00)));
   assign access    = req_any & ~MisalignM;

   always_comb begin
      be_d    = 4'b1111;
      wdata_d = WriteDataM;
      case (Funct3M[1:0])
         2'b00: begin
            be_d    = 4'b0001 << ALUResultM[1:0];
            wdata_d = {4{WriteDataM[7:0]}};
         end
         2'b01: begin
            be_d    = 4'b0011 << ALUResultM[1:0];
            wdata_d = {2{WriteDataM[15:0]}};
         end
         default: ;
      endcase
   end

   assign byte_sel = bus_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

   always_comb begin
      ld_data_d = bus_rdata;
      case (f3_q)
         3'b000:  ld_data_d = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  ld_data_d = {24'h000000, byte_sel};
         3'b001:  ld_data_d = {{16{half_sel[15]}}, half_sel};
         3'b101:  ld_data_d = {16'h0000, half_sel};
         default: ld_data_d = bus_rdata;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         addr_q    <= '0;
         be_q      <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         f3_q      <= '0;
         rdata_q   <= '0;
         bus_req_q <= 1'b0;
         buserr_q  <= 1'b0;
      end else begin
         buserr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (access) begin
                  addr_q    <= ALUResultM;
                  be_q      <= be_d;
                  wdata_q   <= wdata_d;
                  we_q      <= MemWriteM;
                  f3_q      <= Funct3M;
                  cnt_q     <= '0;
                  bus_req_q <= 1'b1;
                  state_q   <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus_gnt) begin
                  bus_req_q <= 1'b0;
                  if (we_q) begin
                     state_q <= S_DONE;
                  end else if (bus_rvalid) begin
                     rdata_q <= ld_data_d;
                     state_q <= S_DONE;
                  end else begin
                     cnt_q   <= '0;
                     state_q <= S_WAIT;
                  end
               end else if (cnt_q == TO_LAST) begin
                  bus_req_q <= 1'b0;
                  buserr_q  <= 1'b1;
                  rdata_q   <= '0;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_WAIT: begin
               if (bus_rvalid) begin
                  rdata_q <= ld_data_d;
                  state_q <= S_DONE;
               end else if (cnt_q == TO_LAST) begin
                  buserr_q <= 1'b1;
                  rdata_q  <= '0;
                  state_q  <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            S_DONE:  state_q <= S_IDLE;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Stall must rise in the accepting cycle, before the state register moves.
   assign StallM    = reset & (((state_q == S_IDLE) & access) |
                               (state_q == S_REQ) | (state_q == S_WAIT));
   assign bus_req   = bus_req_q;
   assign bus_we    = bus_req_q & we_q;
   assign bus_addr  = {addr_q[31:2], 2'b00};
   assign bus_wdata = wdata_q;
   assign bus_be    = be_q;
   assign ReadDataM = rdata_q;
   assign BusErrM   = buserr_q;

endmodule
